// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, header layout and the
// receive-side frame parser states.
package eth_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   localparam int DA_OFS  = 0;
   localparam int SA_OFS  = 6;
   localparam int ET_OFS  = 12;
   localparam int HDR_LEN = 14;
   localparam int FCS_LEN = 4;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      DROP,
      END
   } rx_frame_state_t;

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 advance over one byte, LSB first, reflected polynomial.
// Shared by the receive FCS checker and the transmit FCS generator.
module crc32_byte
   import eth_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] w_crc;

   // Eight bit-serial steps unrolled into one combinational stage
   always_comb begin
      w_crc = i_crc;
      for (int k = 0; k < 8; k++) begin
         w_crc = (w_crc >> 1) ^ (CRC32_POLY & {32{w_crc[0] ^ i_data[k]}});
      end
      o_crc = w_crc;
   end

endmodule

// File: rtl/eth_rx_frame.sv
// Byte-level Ethernet receive frame parser: pulls out DA/SA/EtherType,
// forwards the payload with the FCS stripped and reports per-frame status.
module eth_rx_frame
   import eth_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       byte_i,
   input  logic             byte_valid_i,
   input  logic             frame_active_i,
   input  logic             rx_er_i,
   output logic [47:0]      dst_mac_o,
   output logic [47:0]      src_mac_o,
   output logic [15:0]      ethertype_o,
   output logic             hdr_valid_o,
   output logic [7:0]       pl_data_o,
   output logic             pl_valid_o,
   output logic             frame_end_o,
   output logic             frame_ok_o,
   output logic             crc_err_o,
   output logic             len_err_o,
   output logic             phy_err_o,
   output logic [CNT_W-1:0] frame_len_o
);

   localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
   localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
   localparam logic [2:0]       DL_FULL   = 3'(FCS_LEN);

   rx_frame_state_t         r_state;
   rx_frame_state_t         w_stateNext;
   logic [31:0]             r_crc;
   logic [31:0]             w_crcNext;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cntNext;
   logic                    r_phyErr;
   logic [103:0]            r_hdr;
   logic [FCS_LEN-1:0][7:0] r_dl;
   logic [2:0]              r_dlCnt;
   logic                    w_accept;
   logic                    w_count;
   logic                    w_hdrShift;
   logic                    w_hdrDone;
   logic                    w_plPush;
   logic                    w_toEnd;
   logic                    w_crcErr;
   logic                    w_lenErr;

   assign w_accept  = byte_valid_i && frame_active_i;
   assign w_count   = w_accept && (r_state != END);
   assign w_cntNext = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_crcErr  = (r_crc != CRC32_RESIDUE);
   assign w_lenErr  = (r_cnt < MIN_LEN_C) || (r_cnt > MAX_LEN_C);

   crc32_byte u_crc (
      .i_crc  (r_crc),
      .i_data (byte_i),
      .o_crc  (w_crcNext)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state decode plus the per-byte steering strobes for the datapath
   always_comb begin
      w_stateNext = r_state;
      w_hdrShift  = 1'b0;
      w_hdrDone   = 1'b0;
      w_plPush    = 1'b0;
      w_toEnd     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_stateNext = HEADER;
               w_hdrShift  = 1'b1;
            end
         end
         HEADER: begin
            if (!frame_active_i) begin
               w_stateNext = END;
               w_toEnd     = 1'b1;
            end else if (w_accept) begin
               w_hdrShift = 1'b1;
               if (r_cnt == HDR_LAST) begin
                  w_hdrDone   = 1'b1;
                  w_stateNext = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (!frame_active_i) begin
               w_stateNext = END;
               w_toEnd     = 1'b1;
            end else if (w_accept) begin
               if (w_cntNext > MAX_LEN_C) begin
                  w_stateNext = DROP;
               end else begin
                  w_plPush = 1'b1;
               end
            end
         end
         DROP: begin
            if (!frame_active_i) begin
               w_stateNext = END;
               w_toEnd     = 1'b1;
            end
         end
         END: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Datapath: CRC, byte count, header capture, FCS-hiding delay line, status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_crc       <= CRC32_INIT;
         r_cnt       <= '0;
         r_phyErr    <= 1'b0;
         r_hdr       <= '0;
         r_dl        <= '0;
         r_dlCnt     <= '0;
         dst_mac_o   <= '0;
         src_mac_o   <= '0;
         ethertype_o <= '0;
         hdr_valid_o <= 1'b0;
         pl_data_o   <= '0;
         pl_valid_o  <= 1'b0;
         frame_end_o <= 1'b0;
         frame_ok_o  <= 1'b0;
         crc_err_o   <= 1'b0;
         len_err_o   <= 1'b0;
         phy_err_o   <= 1'b0;
         frame_len_o <= '0;
      end else begin
         hdr_valid_o <= w_hdrDone;
         pl_valid_o  <= 1'b0;
         frame_end_o <= w_toEnd;

         if (r_state == END) begin
            r_crc    <= CRC32_INIT;
            r_cnt    <= '0;
            r_phyErr <= 1'b0;
            r_dlCnt  <= '0;
         end else begin
            if (w_count) begin
               r_crc <= w_crcNext;
               r_cnt <= w_cntNext;
            end
            if ((r_state != IDLE && frame_active_i) || w_count) begin
               r_phyErr <= r_phyErr | rx_er_i;
            end
         end

         if (w_hdrShift) begin
            r_hdr <= {r_hdr[95:0], byte_i};
         end
         if (w_hdrDone) begin
            dst_mac_o   <= r_hdr[103:56];
            src_mac_o   <= r_hdr[55:8];
            ethertype_o <= {r_hdr[7:0], byte_i};
         end

         if (w_plPush) begin
            r_dl <= {r_dl[FCS_LEN-2:0], byte_i};
            if (r_dlCnt == DL_FULL) begin
               pl_data_o  <= r_dl[FCS_LEN-1];
               pl_valid_o <= 1'b1;
            end else begin
               r_dlCnt <= r_dlCnt + 3'd1;
            end
         end

         if (w_toEnd) begin
            crc_err_o   <= w_crcErr;
            len_err_o   <= w_lenErr;
            phy_err_o   <= r_phyErr;
            frame_ok_o  <= !(w_crcErr || w_lenErr || r_phyErr);
            frame_len_o <= r_cnt;
         end
      end
   end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Randomised scoreboard bench for eth_rx_frame. Expected header, payload and
// status records are queued when a frame is issued; a monitor pops them as the
// DUT strobes its outputs.
module tb_eth_rx_frame;
   import eth_pkg::*;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;
   localparam int CNT_W   = 11;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       byte_i;
   logic             byte_valid_i;
   logic             frame_active_i;
   logic             rx_er_i;
   logic [47:0]      dst_mac_o;
   logic [47:0]      src_mac_o;
   logic [15:0]      ethertype_o;
   logic             hdr_valid_o;
   logic [7:0]       pl_data_o;
   logic             pl_valid_o;
   logic             frame_end_o;
   logic             frame_ok_o;
   logic             crc_err_o;
   logic             len_err_o;
   logic             phy_err_o;
   logic [CNT_W-1:0] frame_len_o;

   int nCompared = 0;
   int nFailed   = 0;

   logic [7:0]   frm[$];
   logic [111:0] expHdrQ[$];
   logic [7:0]   expPlQ[$];
   logic [14:0]  expStQ[$];

   eth_rx_frame #(
      .MIN_LEN (MIN_LEN),
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .byte_i         (byte_i),
      .byte_valid_i   (byte_valid_i),
      .frame_active_i (frame_active_i),
      .rx_er_i        (rx_er_i),
      .dst_mac_o      (dst_mac_o),
      .src_mac_o      (src_mac_o),
      .ethertype_o    (ethertype_o),
      .hdr_valid_o    (hdr_valid_o),
      .pl_data_o      (pl_data_o),
      .pl_valid_o     (pl_valid_o),
      .frame_end_o    (frame_end_o),
      .frame_ok_o     (frame_ok_o),
      .crc_err_o      (crc_err_o),
      .len_err_o      (len_err_o),
      .phy_err_o      (phy_err_o),
      .frame_len_o    (frame_len_o)
   );

   // 50 MHz clock
   always #10 clk = ~clk;

   // Single comparison point that keeps the running tallies
   task automatic checkOutput(input string name, input logic [111:0] act, input logic [111:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Standard Ethernet FCS value of the first n bytes of the frame buffer
   function automatic logic [31:0] fcsOf(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 8; k++) begin
            if (c[0] ^ frm[i][k]) c = (c >> 1) ^ CRC32_POLY;
            else                  c = c >> 1;
         end
      end
      return ~c;
   endfunction

   // Header + payload + correct FCS; fixed test header unless randomised
   task automatic buildFrame(input int payLen, input bit randomAll);
      logic [7:0] fixedHdr [14];
      logic [31:0] f;
      fixedHdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                   8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03, 8'h08, 8'h00};
      frm.delete();
      for (int i = 0; i < HDR_LEN; i++)
         frm.push_back(randomAll ? 8'($urandom()) : fixedHdr[i]);
      for (int i = 0; i < payLen; i++)
         frm.push_back(randomAll ? 8'($urandom()) : 8'(i));
      f = fcsOf(frm.size());
      for (int k = 0; k < FCS_LEN; k++) frm.push_back(f[8*k +: 8]);
   endtask

   // Reference model: what the frame in the buffer should produce
   task automatic expectFrame(input bit complete, input bit phyErr);
      int L;
      int fwdEnd;
      logic [111:0] h;
      logic crcErr, lenErr, ok;
      logic [CNT_W-1:0] len;
      L = frm.size();
      h = '0;
      if (L >= HDR_LEN) begin
         for (int i = 0; i < HDR_LEN; i++) h = {h[103:0], frm[i]};
         expHdrQ.push_back(h);
      end
      fwdEnd = ((L < MAX_LEN) ? L : MAX_LEN) - FCS_LEN;
      for (int j = HDR_LEN; j < fwdEnd; j++) expPlQ.push_back(frm[j]);
      if (complete) begin
         if (L < FCS_LEN) crcErr = 1'b1;
         else crcErr = (fcsOf(L - FCS_LEN) != {frm[L-1], frm[L-2], frm[L-3], frm[L-4]});
         lenErr = (L < MIN_LEN) || (L > MAX_LEN);
         len    = (L > 2047) ? 11'd2047 : CNT_W'(L);
         ok     = !(crcErr || lenErr || phyErr);
         expStQ.push_back({len, ok, crcErr, lenErr, phyErr});
      end
   endtask

   // Drive the buffered frame byte by byte with random gaps
   task automatic applyStimulus(input bit complete, input int rxErIdx, input int idleAfter);
      int gap;
      expectFrame(complete, rxErIdx >= 0);
      frame_active_i = 1'b1;
      byte_valid_i   = 1'b0;
      for (int i = 0; i < frm.size(); i++) begin
         gap = (i == 0) ? 1 : int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         byte_valid_i = 1'b1;
         byte_i       = frm[i];
         rx_er_i      = (i == rxErIdx);
         @(negedge clk);
         byte_valid_i = 1'b0;
         rx_er_i      = 1'b0;
      end
      if (complete) begin
         frame_active_i = 1'b0;
         for (int c = 0; c < idleAfter; c++) begin
            byte_valid_i = 1'($urandom_range(0, 1));
            byte_i       = 8'($urandom());
            @(negedge clk);
         end
         byte_valid_i = 1'b0;
      end else begin
         repeat (idleAfter) @(negedge clk);
      end
   endtask

   // Every output should read back as zero while/after reset
   task automatic checkReset();
      checkOutput("resetHdr", {dst_mac_o, src_mac_o, ethertype_o}, '0);
      checkOutput("resetStatus", 112'({frame_len_o, frame_ok_o, crc_err_o, len_err_o, phy_err_o}), '0);
      checkOutput("resetStrobes", 112'({hdr_valid_o, pl_valid_o, frame_end_o, pl_data_o}), '0);
   endtask

   // Monitor: pop and compare whenever the DUT strobes an output
   always @(negedge clk) begin
      if (!rst) begin
         if (hdr_valid_o) begin
            if (expHdrQ.size() == 0) checkOutput("unexpectedHdr", 112'd1, 112'd0);
            else checkOutput("header", {dst_mac_o, src_mac_o, ethertype_o}, expHdrQ.pop_front());
         end
         if (pl_valid_o) begin
            if (expPlQ.size() == 0) checkOutput("unexpectedPayload", 112'd1, 112'd0);
            else checkOutput("payload", 112'(pl_data_o), 112'(expPlQ.pop_front()));
         end
         if (frame_end_o) begin
            if (expStQ.size() == 0) checkOutput("unexpectedFrameEnd", 112'd1, 112'd0);
            else checkOutput("status", 112'({frame_len_o, frame_ok_o, crc_err_o, len_err_o, phy_err_o}),
                             112'(expStQ.pop_front()));
         end
      end
   end

   // Watchdog so the run always terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared + 1, nFailed + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      int idx;
      rst            = 1'b1;
      byte_i         = '0;
      byte_valid_i   = 1'b0;
      frame_active_i = 1'b0;
      rx_er_i        = 1'b0;
      repeat (3) @(negedge clk);
      checkReset();
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] good 64-byte frame");
      buildFrame(46, 1'b0);
      applyStimulus(1'b1, -1, 4);

      $display("[TB] payload byte 10 corrupted");
      buildFrame(46, 1'b0);
      frm[HDR_LEN + 10] = 8'hFF;
      applyStimulus(1'b1, -1, 4);

      $display("[TB] 40-byte runt");
      buildFrame(22, 1'b1);
      applyStimulus(1'b1, -1, 4);

      $display("[TB] 10-byte fragment");
      frm.delete();
      for (int i = 0; i < 10; i++) frm.push_back(8'($urandom()));
      applyStimulus(1'b1, -1, 4);

      $display("[TB] 1600-byte giant");
      buildFrame(1582, 1'b1);
      applyStimulus(1'b1, -1, 4);

      $display("[TB] rx_er mid-payload");
      buildFrame(46, 1'b0);
      applyStimulus(1'b1, 30, 4);

      $display("[TB] back-to-back frames");
      buildFrame(46, 1'b1);
      applyStimulus(1'b1, -1, 1);
      buildFrame(60, 1'b1);
      applyStimulus(1'b1, -1, 4);

      $display("[TB] reset mid-payload");
      buildFrame(46, 1'b0);
      while (frm.size() > 30) void'(frm.pop_back());
      applyStimulus(1'b0, -1, 3);
      rst            = 1'b1;
      frame_active_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkReset();
      rst = 1'b0;
      @(negedge clk);
      buildFrame(46, 1'b0);
      applyStimulus(1'b1, -1, 4);

      $display("[TB] random frames");
      repeat (8) begin
         buildFrame(int'($urandom_range(0, 80)), 1'b1);
         if ($urandom_range(0, 2) == 0) begin
            idx      = int'($urandom_range(0, frm.size() - 1));
            frm[idx] = frm[idx] ^ 8'h01;
         end
         applyStimulus(1'b1,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, frm.size() - 1)) : -1,
                       int'($urandom_range(1, 5)));
      end

      repeat (10) @(negedge clk);
      checkOutput("hdrQueueLeft", 112'(expHdrQ.size()), '0);
      checkOutput("payloadQueueLeft", 112'(expPlQ.size()), '0);
      checkOutput("statusQueueLeft", 112'(expStQ.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
